// File: rtl/multi_lane_reduction.sv
// Multi-lane BRAM reduction engine: streams an inclusive address range and reduces each lane
// (sum / max / min / scaled sum), optionally collapsing all lanes into one scalar.
module multi_lane_reduction #(
    parameter int unsigned DATA_W    = 20,
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned OUT_W     = 28
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               start_addr,
    input  logic [ADDR_W-1:0]               end_addr,
    input  logic [1:0]                      reduction_type,
    input  logic [3:0]                      shift_amt,
    input  logic                            lane_collapse,
    input  logic                            bram_in_we,
    input  logic [ADDR_W-1:0]               bram_in_addr_ext,
    input  logic [NUM_LANES*DATA_W-1:0]     bram_in_wdata_ext,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [NUM_LANES*OUT_W-1:0]      reduced_out,
    output logic [OUT_W-1:0]                reduced_scalar
);

    localparam int unsigned ACC_W  = DATA_W + ADDR_W + 1;
    localparam int unsigned LOG_L  = $clog2(NUM_LANES);
    // Cross-lane sums need log2(NUM_LANES) extra bits on top of the lane accumulator.
    localparam int unsigned TREE_W = ACC_W + LOG_L;
    localparam int unsigned LIDX_W = (LOG_L > 0) ? LOG_L : 1;
    localparam int unsigned SAT_W  = ((TREE_W > OUT_W) ? TREE_W : OUT_W) + 1;
    localparam int unsigned WORD_W = NUM_LANES * DATA_W;

    typedef enum logic [2:0] {StIdle, StRead, StDrain, StCollapse, StDone} state_e;

    function automatic logic signed [TREE_W-1:0] combine(input logic signed [TREE_W-1:0] a,
                                                         input logic signed [TREE_W-1:0] b,
                                                         input logic [1:0] typ);
        logic signed [TREE_W-1:0] r;
        case (typ)
            2'd1:    r = (a > b) ? a : b;
            2'd2:    r = (a < b) ? a : b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    function automatic logic signed [OUT_W-1:0] finalize(input logic signed [TREE_W-1:0] v,
                                                         input logic [1:0] typ,
                                                         input logic [3:0] sh);
        logic signed [TREE_W-1:0] t;
        logic signed [SAT_W-1:0]  x, hi, lo;
        logic signed [OUT_W-1:0]  r;
        t = v;
        if (typ == 2'd3) t = v >>> sh;
        x = SAT_W'(t);
        hi = '0;
        hi[OUT_W-2:0] = '1;
        lo = ~hi;
        if (x > hi)      r = hi[OUT_W-1:0];
        else if (x < lo) r = lo[OUT_W-1:0];
        else             r = x[OUT_W-1:0];
        return r;
    endfunction

    state_e state_q, state_d;

    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] rdata_q;
    logic              rvalid_q, first_q, start_q, empty_q;
    logic [ADDR_W-1:0] addr_q, end_q;
    logic [1:0]        type_q;
    logic [3:0]        shift_q;
    logic              collapse_q;
    logic [LIDX_W-1:0] lvl_q;

    logic signed [ACC_W-1:0]  lane_v   [NUM_LANES];
    logic signed [ACC_W-1:0]  acc_q    [NUM_LANES];
    logic signed [ACC_W-1:0]  acc_d    [NUM_LANES];
    logic signed [ACC_W-1:0]  lane_fin [NUM_LANES];
    logic signed [TREE_W-1:0] tree_q   [NUM_LANES];
    logic signed [TREE_W-1:0] tree_d   [NUM_LANES];

    logic [NUM_LANES*OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0]           scalar_q, scalar_d;
    logic                       err_q;

    logic accept, empty_range, last_read, last_lvl, enter_done;

    assign empty_range = end_addr < start_addr;
    assign accept      = (state_q == StIdle) && !empty_q && start && !start_q;
    assign last_read   = addr_q == end_q;
    assign last_lvl    = lvl_q == LIDX_W'(LOG_L - 1);
    assign enter_done  = (state_d == StDone) && (state_q != StDone);

    assign busy           = state_q != StIdle;
    assign done           = state_q == StDone;
    assign err            = err_q;
    assign reduced_out    = out_q;
    assign reduced_scalar = scalar_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            // An empty range resolves one cycle after accept, matching the N = 0 schedule.
            StIdle:     if (empty_q) state_d = StDone;
                        else if (accept && !empty_range) state_d = StRead;
            StRead:     if (last_read) state_d = StDrain;
            StDrain:    state_d = (collapse_q && LOG_L > 0) ? StCollapse : StDone;
            StCollapse: if (last_lvl) state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_v[i] = ACC_W'($signed(rdata_q[i*DATA_W +: DATA_W]));
            acc_d[i]  = acc_q[i];
            if (rvalid_q) begin
                acc_d[i] = first_q ? lane_v[i]
                                   : ACC_W'(combine(TREE_W'(acc_q[i]), TREE_W'(lane_v[i]),
                                                    type_q));
            end
            lane_fin[i] = (state_q == StDrain) ? acc_d[i] : acc_q[i];
        end
    end

    // One tree level per cycle: the lower half of the live lanes absorbs the upper half.
    always_comb begin
        int unsigned       half;
        logic [LIDX_W-1:0] p;
        half = NUM_LANES >> (32'(lvl_q) + 32'd1);
        p    = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            tree_d[i] = tree_q[i];
            if (i < half) begin
                p = LIDX_W'(i + half);
                tree_d[i] = combine(tree_q[i], tree_q[p], type_q);
            end
        end
    end

    always_comb begin
        logic signed [TREE_W-1:0] scalar_src;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            out_d[i*OUT_W +: OUT_W] = finalize(TREE_W'(lane_fin[i]), type_q, shift_q);
        end
        scalar_src = (LOG_L == 0) ? TREE_W'(lane_fin[0]) : tree_d[0];
        scalar_d   = collapse_q ? finalize(scalar_src, type_q, shift_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (bram_in_we && state_q == StIdle) mem[bram_in_addr_ext] <= bram_in_wdata_ext;
        if (state_q == StRead) rdata_q <= mem[addr_q];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            empty_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            first_q    <= 1'b0;
            addr_q     <= '0;
            end_q      <= '0;
            type_q     <= '0;
            shift_q    <= '0;
            collapse_q <= 1'b0;
            lvl_q      <= '0;
            err_q      <= 1'b0;
            out_q      <= '0;
            scalar_q   <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                acc_q[i]  <= '0;
                tree_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            empty_q  <= accept && empty_range;
            rvalid_q <= state_q == StRead;
            if (accept) begin
                addr_q     <= start_addr;
                end_q      <= end_addr;
                type_q     <= reduction_type;
                shift_q    <= shift_amt;
                collapse_q <= lane_collapse;
                first_q    <= 1'b1;
                lvl_q      <= '0;
            end
            if (state_q == StRead && !last_read) addr_q <= addr_q + ADDR_W'(1);
            if (rvalid_q) first_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                acc_q[i] <= acc_d[i];
                if (state_q == StDrain)         tree_q[i] <= TREE_W'(acc_d[i]);
                else if (state_q == StCollapse) tree_q[i] <= tree_d[i];
            end
            if (state_q == StCollapse) lvl_q <= lvl_q + LIDX_W'(1);
            if (enter_done) begin
                if (empty_q) begin
                    err_q    <= 1'b1;
                    out_q    <= '0;
                    scalar_q <= '0;
                end else begin
                    err_q    <= 1'b0;
                    out_q    <= out_d;
                    scalar_q <= scalar_d;
                end
            end
        end
    end

endmodule

// File: doc/multi_lane_reduction.md
# multi_lane_reduction

Parametrised, multi-lane successor to the single-channel reduction layer. It holds an internal BRAM loaded through an external write port. On a start request it streams the inclusive address range [start_addr, end_addr] and reduces each lane independently: sum, max, min, or scaled sum. Optionally it also collapses all lanes into one scalar. It sits after the matmul output buffer and feeds pooling/normalisation stages.

## Interface
- DATA_W, 20: signed element width per lane.
- NUM_LANES, 4: lanes packed per BRAM word; power of two, ≥1.
- ADDR_W, 11: BRAM address width; depth = 2**ADDR_W.
- OUT_W, 28: signed width of each result; ≥ DATA_W.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; rising edge is accepted only in IDLE.
- start_addr  in  ADDR_W  first word, inclusive.
- end_addr  in  ADDR_W  last word, inclusive.
- reduction_type  in  2  0 = sum, 1 = max, 2 = min, 3 = scaled sum.
- shift_amt  in  4  arithmetic right shift, used by type 3 only.
- lane_collapse  in  1  1 = also reduce across lanes into reduced_scalar.
- bram_in_we  in  1  external write enable.
- bram_in_addr_ext  in  ADDR_W  external write address.
- bram_in_wdata_ext  in  NUM_LANES*DATA_W  write data; lane i = bits [i*DATA_W +: DATA_W].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = empty range (end_addr < start_addr).
- reduced_out  out  NUM_LANES*OUT_W  per-lane results; lane i = bits [i*OUT_W +: OUT_W].
- reduced_scalar  out  OUT_W  cross-lane result; 0 when lane_collapse = 0.

## Operation
- Start detection: start is registered into start_d. Accept when state = IDLE and start & ~start_d. A held-high start does not retrigger.
- On accept, capture start_addr, end_addr, reduction_type, shift_amt and lane_collapse. Later changes to these inputs are ignored until the next accept.
- Empty range (end_addr < start_addr): go straight to DONE with err = 1, all outputs 0, and no reads.
- States and transitions:
  - IDLE -> READ on accept; IDLE -> DONE on accept of an empty range.
  - READ: issue one read per cycle for N = end_addr − start_addr + 1 cycles, then -> DRAIN.
  - DRAIN: one cycle; the last read data is accumulated. -> COLLAPSE if lane_collapse, else -> DONE.
  - COLLAPSE: C = log2(NUM_LANES) cycles (one tree level per cycle), then -> DONE. When NUM_LANES = 1, C = 0.
  - DONE: one cycle, done = 1, then -> IDLE.
- BRAM read latency is 1 cycle. The first returned word initialises the lane accumulators; later words combine with them.
- Accumulators are signed, ACC_W = DATA_W + ADDR_W + 1 bits, so no internal overflow is possible.
- Sum (type 0): per-lane sum.
- Max / min (types 1 and 2): signed compare. The result is sign-extended to OUT_W.
- Scaled sum (type 3): sum >>> shift_amt, arithmetic shift, truncating toward −inf.
- Output rule for sum and scaled sum: saturate the wide value to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Collapse:
  - Operates on the un-saturated wide per-lane values, using the same operator.
  - For type 3, lanes are summed first and shift/saturate is applied once, at the end.
- External writes:
  - Honoured in IDLE only.
  - Ignored in all other states, so RAM contents stay stable during a reduction.
- Outputs: reduced_out, reduced_scalar and err are updated on the edge entering DONE and hold until the next DONE.

## Timing
- Reset (resetn = 0, asynchronous):
  - state = IDLE; busy = done = err = 0; reduced_out = reduced_scalar = 0; start_d = 0.
  - RAM contents are not reset.
- Reset asserted mid-operation aborts immediately; no done pulse follows. After release the block is in IDLE and needs a fresh start edge.
- Let E0 be the accepting edge:
  - busy rises after E0.
  - done is high for the single cycle after edge E0+N+1+C, and busy is also high in that cycle.
  - busy falls after edge E0+N+2+C.
- Empty range: done high in the cycle after E0+1.
- A start edge during busy is ignored, not queued.
- A start edge in the cycle that done is high is ignored.
- A write in the same cycle as the accepting edge is honoured, because the block was in IDLE.

## Test plan
- Load words 0..5 with lanes {1,2,3,4}·(addr+1); type 0, range 0..5, no collapse. Expect reduced_out = {21,42,63,84}, done after E0+7 for one cycle, err = 0.
- Same data and range, type 1 then type 2. Expect max = {6,12,18,24}, min = {1,2,3,4}. Then lane_collapse = 1 with type 1: reduced_scalar = 24, done after E0+9.
- All lanes 0x7FFFF (max positive 20-bit) at all 2048 addresses, type 0. Expect each lane saturated to 2^27−1. Type 3 with shift_amt = 11: expect 0x7FFFF per lane, unsaturated.
- start_addr = 9, end_addr = 4: done after E0+1, err = 1, outputs 0, busy high for exactly one cycle.
- Hold start high for 8 cycles with range 3..3. Expect exactly one done pulse. Writes to address 3 during busy leave the result unchanged.
- Assert resetn low during READ. Expect all outputs 0 asynchronously and no done pulse. A new start then gives a correct result, and RAM contents are preserved.
